// File: rtl/cp_insert.sv
// cp_insert: cyclic-prefix inserter with ping-pong symbol buffer and back-pressure
module cp_insert #(
  parameter int N      = 64,
  parameter int CP_LEN = 16,
  parameter int W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                in_sop,
  input  logic                in_valid,
  input  logic signed [W-1:0] in_i,
  input  logic signed [W-1:0] in_q,
  output logic                in_ready,
  output logic signed [W-1:0] out_i,
  output logic signed [W-1:0] out_q,
  output logic                out_valid,
  output logic                sop_out,
  output logic                eop_out,
  output logic                sop_err
);
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] CP_START = AW'(N - CP_LEN);
  localparam logic [AW-1:0] LAST     = AW'(N - 1);

  typedef enum logic {WR_IDLE, WR_FILL} wr_st_t;
  typedef enum logic [1:0] {RD_IDLE, RD_CP, RD_BODY} rd_st_t;

  wr_st_t        wr_st_q, wr_st_d;
  logic          wr_bank_q, wr_bank_d;
  logic [AW-1:0] wr_idx_q, wr_idx_d;
  logic [1:0]    full_q, full_d;
  logic          sop_err_q, sop_err_d;
  rd_st_t        rd_st_q, rd_st_d;
  logic          rd_bank_q, rd_bank_d;
  logic          iss_v_q, iss_v_d;
  logic          iss_bank_q, iss_bank_d;
  logic [AW-1:0] iss_addr_q, iss_addr_d;
  logic          iss_sop_q, iss_sop_d;
  logic          iss_eop_q, iss_eop_d;
  logic [2*W-1:0] dout_q;
  logic          ov_q, os_q, oe_q;
  logic [2*W-1:0] mem [2*N];

  logic          accept, we, wr_set, rd_clr, start;
  logic [AW-1:0] waddr, nxt;

  assign in_ready  = ~full_q[wr_bank_q];
  assign accept    = in_valid & in_ready;
  assign out_i     = dout_q[2*W-1:W];
  assign out_q     = dout_q[W-1:0];
  assign out_valid = ov_q & en;
  assign sop_out   = os_q & en;
  assign eop_out   = oe_q & en;
  assign sop_err   = sop_err_q;

  // write side: idle drops samples until an sop, fill walks indices 0..N-1 and restarts on a stray sop
  always_comb begin
    wr_st_d   = wr_st_q;
    wr_bank_d = wr_bank_q;
    wr_idx_d  = wr_idx_q;
    sop_err_d = 1'b0;
    we        = 1'b0;
    waddr     = wr_idx_q;
    wr_set    = 1'b0;
    if (accept && in_sop) begin
      we        = 1'b1;
      waddr     = '0;
      wr_idx_d  = AW'(1);
      wr_st_d   = WR_FILL;
      sop_err_d = (wr_st_q == WR_FILL);
    end else if (accept && wr_st_q == WR_FILL) begin
      we       = 1'b1;
      wr_idx_d = wr_idx_q + AW'(1);
      if (wr_idx_q == LAST) begin
        wr_set    = 1'b1;
        wr_bank_d = ~wr_bank_q;
        wr_st_d   = WR_IDLE;
      end
    end
  end

  // read side: issue prefix addresses then body addresses; a finished body may chain straight into the other bank
  always_comb begin
    rd_st_d    = rd_st_q;
    rd_bank_d  = rd_bank_q;
    iss_v_d    = iss_v_q;
    iss_bank_d = iss_bank_q;
    iss_addr_d = iss_addr_q;
    iss_sop_d  = iss_sop_q;
    iss_eop_d  = iss_eop_q;
    rd_clr     = 1'b0;
    nxt        = iss_addr_q + AW'(1);
    start      = (rd_st_q == RD_IDLE) || (rd_st_q == RD_BODY && iss_addr_q == LAST);
    if (en) begin
      iss_v_d   = 1'b0;
      iss_sop_d = 1'b0;
      iss_eop_d = 1'b0;
      if (start) begin
        rd_st_d = RD_IDLE;
        if (full_q[rd_bank_q]) begin
          iss_v_d    = 1'b1;
          iss_sop_d  = 1'b1;
          iss_addr_d = CP_START;
          iss_bank_d = rd_bank_q;
          rd_st_d    = RD_CP;
        end
      end else begin
        iss_v_d    = 1'b1;
        iss_addr_d = nxt;
        if (rd_st_q == RD_CP) begin
          if (iss_addr_q == LAST) rd_st_d = RD_BODY;
        end else if (nxt == LAST) begin
          iss_eop_d = 1'b1;
          rd_clr    = 1'b1;
          rd_bank_d = ~rd_bank_q;
        end
      end
    end
  end

  // bank-full flags: writer sets its bank, reader clears its bank; the two are never the same bank
  always_comb begin
    full_d = full_q;
    if (wr_set) full_d[wr_bank_q] = 1'b1;
    if (rd_clr) full_d[rd_bank_q] = 1'b0;
  end

  // symbol storage, write port
  always_ff @(posedge clk) begin
    if (we) mem[{wr_bank_q, waddr}] <= {in_i, in_q};
  end

  // state registers and the synchronous-read output stage, frozen while en is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_st_q    <= WR_IDLE;
      wr_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      full_q     <= '0;
      sop_err_q  <= 1'b0;
      rd_st_q    <= RD_IDLE;
      rd_bank_q  <= 1'b0;
      iss_v_q    <= 1'b0;
      iss_bank_q <= 1'b0;
      iss_addr_q <= '0;
      iss_sop_q  <= 1'b0;
      iss_eop_q  <= 1'b0;
      dout_q     <= '0;
      ov_q       <= 1'b0;
      os_q       <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      wr_st_q    <= wr_st_d;
      wr_bank_q  <= wr_bank_d;
      wr_idx_q   <= wr_idx_d;
      full_q     <= full_d;
      sop_err_q  <= sop_err_d;
      rd_st_q    <= rd_st_d;
      rd_bank_q  <= rd_bank_d;
      iss_v_q    <= iss_v_d;
      iss_bank_q <= iss_bank_d;
      iss_addr_q <= iss_addr_d;
      iss_sop_q  <= iss_sop_d;
      iss_eop_q  <= iss_eop_d;
      if (en && iss_v_q) dout_q <= mem[{iss_bank_q, iss_addr_q}];
      if (en) begin
        ov_q <= iss_v_q;
        os_q <= iss_sop_q;
        oe_q <= iss_eop_q;
      end
    end
  end
endmodule

// File: tb/tb_cp_insert.sv
// tb_cp_insert: table-driven check of cyclic-prefix insertion, back-pressure, restart, stalls and reset
module tb_cp_insert;
  localparam int N = 64, CP = 16, W = 16;

  logic clk = 1'b0, rst = 1'b0, en = 1'b1, in_sop = 1'b0, in_valid = 1'b0;
  logic signed [W-1:0] in_i = '0, in_q = '0;
  logic in_ready, out_valid, sop_out, eop_out, sop_err;
  logic signed [W-1:0] out_i, out_q;

  cp_insert #(.N(N), .CP_LEN(CP), .W(W)) dut (
    .clk(clk), .rst(rst), .en(en), .in_sop(in_sop), .in_valid(in_valid),
    .in_i(in_i), .in_q(in_q), .in_ready(in_ready), .out_i(out_i), .out_q(out_q),
    .out_valid(out_valid), .sop_out(sop_out), .eop_out(eop_out), .sop_err(sop_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int base; int nsym; int restart; bit tog;
    int exp_cnt; int exp_err; int exp_first_i; int exp_span; int exp_lat; bit exp_stall;
  } vec_t;

  vec_t vecs[5];
  int total = 0, bad = 0, cyc = 0, stall = 0, errs = 0, gate_bad = 0, acc_cyc = 0;
  bit en_mode = 1'b0;
  int qi[$], qq[$], qf[$], qc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      qi.push_back(int'(out_i));
      qq.push_back(int'(out_q));
      qf.push_back(int'({sop_out, eop_out}));
      qc.push_back(cyc);
    end
    if (sop_err) errs++;
    if (out_valid && !en) gate_bad++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    en = en_mode ? ~en : 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input bit sop, input int i, input int q);
    int g = 0;
    in_sop = sop; in_i = W'(i); in_q = W'(q); in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && g < 3000) begin
      stall++; g++;
      @(negedge clk);
    end
    check("in_ready_wait", int'(in_ready), 1);
    @(posedge clk);
    #1;
    acc_cyc = cyc; in_valid = 1'b0; in_sop = 1'b0;
  endtask

  task automatic clear_q();
    qi.delete(); qq.delete(); qf.delete(); qc.delete();
    errs = 0; stall = 0; gate_bad = 0;
  endtask

  task automatic run_vec(input vec_t v);
    int first_acc = 0, n = 0, p, s, val, last;
    clear_q();
    en_mode = v.tog;
    send(1'b0, -5, 5);
    send(1'b0, -6, 6);
    for (int k = 0; k < v.restart; k++) send(k == 0, 7000 + k, -7000 - k);
    for (int sy = 0; sy < v.nsym; sy++) begin
      for (int k = 0; k < N; k++) send(k == 0, v.base + 100*sy + k, -(v.base + 100*sy + k));
      if (sy == 0) first_acc = acc_cyc;
    end
    while (qi.size() < v.exp_cnt && n < 4000) begin
      @(negedge clk);
      n++;
    end
    repeat (30) @(negedge clk);
    en_mode = 1'b0;
    check($sformatf("count base=%0d", v.base), qi.size(), v.exp_cnt);
    if (qi.size() > 0) begin
      last = qi.size() - 1;
      check($sformatf("first_i base=%0d", v.base), qi[0], v.exp_first_i);
      check($sformatf("span base=%0d", v.base), qc[last] - qc[0], v.exp_span);
      if (v.exp_lat > 0) check($sformatf("latency base=%0d", v.base), qc[0] - first_acc, v.exp_lat);
    end
    for (int j = 0; j < qi.size() && j < v.exp_cnt; j++) begin
      s = j / (N + CP);
      p = j % (N + CP);
      val = v.base + 100*s + ((p < CP) ? (N - CP + p) : (p - CP));
      check($sformatf("out_i[%0d] base=%0d", j, v.base), qi[j], val);
      check($sformatf("out_q[%0d] base=%0d", j, v.base), qq[j], -val);
      check($sformatf("sop_eop[%0d] base=%0d", j, v.base), qf[j], (p == 0 ? 2 : 0) + (p == N + CP - 1 ? 1 : 0));
    end
    check($sformatf("sop_err base=%0d", v.base), errs, v.exp_err);
    check($sformatf("stalled base=%0d", v.base), int'(stall > 0), int'(v.exp_stall));
    check($sformatf("valid_gate base=%0d", v.base), gate_bad, 0);
  endtask

  initial begin
    vecs[0] = '{base: 0,    nsym: 1, restart: 0,  tog: 1'b0, exp_cnt: 80,  exp_err: 0, exp_first_i: 48,   exp_span: 79,  exp_lat: 2, exp_stall: 1'b0};
    vecs[1] = '{base: 0,    nsym: 2, restart: 0,  tog: 1'b0, exp_cnt: 160, exp_err: 0, exp_first_i: 48,   exp_span: 159, exp_lat: 2, exp_stall: 1'b0};
    vecs[2] = '{base: 0,    nsym: 3, restart: 0,  tog: 1'b0, exp_cnt: 240, exp_err: 0, exp_first_i: 48,   exp_span: 239, exp_lat: 2, exp_stall: 1'b1};
    vecs[3] = '{base: 300,  nsym: 1, restart: 20, tog: 1'b0, exp_cnt: 80,  exp_err: 1, exp_first_i: 348,  exp_span: 79,  exp_lat: 2, exp_stall: 1'b0};
    vecs[4] = '{base: 1000, nsym: 1, restart: 0,  tog: 1'b1, exp_cnt: 80,  exp_err: 0, exp_first_i: 1048, exp_span: 158, exp_lat: 0, exp_stall: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_i", int'(out_i), 0);
    check("rst_sop_err", int'(sop_err), 0);
    check("rst_in_ready", int'(in_ready), 1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int v = 0; v < 5; v++) run_vec(vecs[v]);

    begin
      int n = 0;
      clear_q();
      for (int k = 0; k < N; k++) send(k == 0, 2000 + k, -(2000 + k));
      while (qi.size() < 30 && n < 500) begin
        @(negedge clk);
        #1;
        n++;
      end
      check("pre_rst_valid", int'(out_valid), 1);
      check("pre_rst_out_i", int'(out_i), 2013);
      rst = 1'b0;
      #1;
      check("async_rst_out_i", int'(out_i), 0);
      check("async_rst_out_q", int'(out_q), 0);
      check("async_rst_out_valid", int'(out_valid), 0);
      check("async_rst_sop_eop", int'({sop_out, eop_out}), 0);
      check("async_rst_in_ready", int'(in_ready), 1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      clear_q();
      check("post_rst_in_ready", int'(in_ready), 1);
      repeat (100) @(negedge clk);
      check("residual_outputs", qi.size(), 0);
      run_vec('{base: 3000, nsym: 1, restart: 0, tog: 1'b0, exp_cnt: 80, exp_err: 0, exp_first_i: 3048, exp_span: 79, exp_lat: 2, exp_stall: 1'b0});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cp_insert.md
Name: cp_insert

Overview:
- Cyclic-prefix inserter; sits directly downstream of the IFFT output spectrum-reversal stage in the OFDM transmit chain.
- Buffers each N-sample complex time-domain symbol in a ping-pong RAM.
- Emits CP_LEN prefix samples (the last CP_LEN samples of the symbol), then the full N-sample symbol, one sample per enabled cycle.
- Back-pressures the upstream stage with in_ready.

Parameters:
N, 64, samples per OFDM symbol (power of 2, ≥4)
CP_LEN, 16, prefix length (1 ≤ CP_LEN < N)
W, 16, signed sample width of I and Q

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
en  in  1  output-side clock enable; 0 stalls the read pipeline
in_sop  in  1  marks sample 0 of a symbol, qualified by in_valid
in_valid  in  1  input sample valid
in_i  in  W  signed input I
in_q  in  W  signed input Q
in_ready  out  1  high when the current write bank can accept a sample
out_i  out  W  signed output I
out_q  out  W  signed output Q
out_valid  out  1  output sample valid
sop_out  out  1  high with the first prefix sample of each symbol
eop_out  out  1  high with body sample N-1 of each symbol
sop_err  out  1  one-cycle pulse when in_sop arrives mid-fill

Behaviour:
- Reset (rst=0, asynchronous):
  - outputs: out_i/out_q=0, out_valid/sop_out/eop_out/sop_err=0.
  - Both bank-full flags cleared; write bank=0; both FSMs idle.
  - in_ready=1 after reset.
  - Reset mid-symbol discards all buffered and in-flight data.
- Storage: two banks of N×(2W) dual-port RAM with synchronous read (1-cycle read latency).
- Write side:
  - Sample accepted iff in_valid & in_ready.
  - in_ready = ~full[wr_bank].
  - WR_IDLE: accepted samples without in_sop are dropped. An accepted in_sop sample is written at index 0 and moves the FSM to WR_FILL.
  - WR_FILL: each accepted sample is written at the next index. On the edge accepting index N-1: full[wr_bank] is set, wr_bank toggles, FSM returns to WR_IDLE.
  - in_sop accepted in WR_FILL at index ≠ 0: restart at index 0 in the same bank; sop_err pulses for one cycle.
- Read side (FSM RD_IDLE → RD_CP → RD_BODY), advances only when en=1:
  - RD_IDLE: if full[rd_bank], issue address N-CP_LEN and go to RD_CP.
  - RD_CP: addresses N-CP_LEN..N-1, then address 0 and go to RD_BODY.
  - RD_BODY: addresses 0..N-1. On issuing N-1:
    - clear full[rd_bank] and toggle rd_bank.
    - If the other bank is full, issue its address N-CP_LEN next cycle (no gap); otherwise go to RD_IDLE.
  - full-flag set (write) and clear (read) on the same cycle touch different banks, so there is no conflict.
- Output timing:
  - out_valid is asserted one enabled cycle after each address issue.
  - Latency: the first prefix sample appears 2 cycles after the edge that accepted input index N-1 (en held high).
  - Each symbol produces exactly N+CP_LEN consecutive valid outputs.
- en=0: read address, FSM and RAM output register hold; out_i/out_q hold; out_valid/sop_out/eop_out forced 0. Resumes with no lost or duplicated samples.
- Data passes bit-exact: no arithmetic, no width change.
- Throughput: sustained input of 1 sample/cycle is not possible. When both banks are full, in_ready stays low until the reader clears a bank.

Test Plan:
- Reset, en=1, one symbol in_i=k, in_q=-k for k=0..63 with in_sop at k=0. Required response:
  - 80 consecutive out_valid cycles, out_i=48..63 then 0..63, out_q the negatives.
  - sop_out on out_i=48; eop_out on the final out_i=63.
  - First output 2 cycles after k=63 is accepted.
- Two symbols back-to-back (second symbol samples offset +100) → 160 consecutive valid outputs with no gap; the second prefix starts at out_i=148.
- Three symbols presented continuously → in_ready drops after the second symbol fills; the third symbol is accepted only after a bank is freed. All 240 outputs are correct and in order.
- in_sop reasserted at index 20 of a fill → sop_err pulses once; the output symbol contains only the restarted data (64 new samples).
- en toggled 1/0 every cycle during readout → same 80-sample sequence; out_valid only on en=1 cycles; no repeats or drops.
- rst driven low mid-readout at output 30 → all outputs 0 immediately (asynchronous); after release, in_ready=1, no residual outputs, and a new symbol reads out correctly.
